// File: rtl/aes_ecb_stream_ctrl_pkg.sv
// Shared definitions for the AES-256 ECB stream controller: word/block geometry
// and the controller state encoding.
package aes_ecb_stream_ctrl_pkg;

  localparam int WORD_W           = 32;
  localparam int BLOCK_WORDS      = 4;
  localparam int BLOCK_W          = WORD_W * BLOCK_WORDS;
  localparam int AES256_KEY_WORDS = 8;

  typedef enum logic [1:0] {
    C_KEY  = 2'd0,
    C_IDLE = 2'd1,
    C_RUN  = 2'd2,
    C_PEND = 2'd3
  } ctrl_state_t;

endpackage

// File: rtl/aes_ecb_stream_ctrl_word_buf.sv
// Word-granular 128-bit shift buffer with occupancy count. Used as the plaintext
// SIPO (push words, read the whole block) and as the ciphertext PISO (load a block, pop words).
module aes_word_sipo_piso #(
  parameter int WORD_W    = 32,
  parameter int WORDS     = 4,
  parameter int OUT_WORDS = WORDS
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              push,
  input  logic [WORD_W-1:0]                 push_word,
  input  logic                              pop,
  input  logic                              load,
  input  logic [WORD_W*WORDS-1:0]           load_data,
  input  logic                              clear,
  output logic [WORD_W*OUT_WORDS-1:0]       data,
  output logic [$clog2(WORDS+1)-1:0]        count
);

  localparam int BUF_W = WORD_W * WORDS;
  localparam int OUT_W = WORD_W * OUT_WORDS;
  localparam int CNT_W = $clog2(WORDS + 1);

  logic [BUF_W-1:0] buf_q;

  // Parallel load beats a same-cycle pop so a drained PISO refills without a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q <= '0;
      count <= '0;
    end else if (load) begin
      buf_q <= load_data;
      count <= CNT_W'(WORDS);
    end else if (clear) begin
      count <= '0;
    end else if (push) begin
      buf_q <= {buf_q[BUF_W-WORD_W-1:0], push_word};
      count <= count + 1'b1;
    end else if (pop) begin
      buf_q <= {buf_q[BUF_W-WORD_W-1:0], {WORD_W{1'b0}}};
      count <= count - 1'b1;
    end
  end

  assign data = buf_q[BUF_W-1 -: OUT_W];

endmodule

// File: rtl/aes_ecb_stream_ctrl.sv
// Stream wrapper around the AES-256 ECB core: assembles key and plaintext words,
// sequences core starts, and serialises ciphertext onto a valid/ready stream.
//
// state  | meaning
// C_KEY  | key words being loaded, no starts
// C_IDLE | key loaded, start when a full block is buffered
// C_RUN  | core busy, waiting for done
// C_PEND | result ready but output buffer still draining
module aes_ecb_stream_ctrl
  import aes_ecb_stream_ctrl_pkg::*;
#(
  parameter int KEY_WORDS = AES256_KEY_WORDS,
  parameter int BLK_CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          key_in,
  input  logic                 key_in_valid,
  output logic                 key_in_ready,
  input  logic [31:0]          s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic [31:0]          m_data,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic                 m_last,
  output logic [31:0]          core_key_word,
  output logic                 core_valid_word,
  output logic                 core_start,
  output logic [127:0]         core_plain_text,
  input  logic                 core_done,
  input  logic [127:0]         core_cipher_text,
  output logic [BLK_CNT_W-1:0] blk_count
);

  localparam int KCNT_W = (KEY_WORDS > 1) ? $clog2(KEY_WORDS) : 1;
  localparam logic [KCNT_W-1:0] KEY_LAST = KCNT_W'(KEY_WORDS - 1);
  localparam int CNT_W = $clog2(BLOCK_WORDS + 1);
  localparam logic [CNT_W-1:0] BLK_FULL = CNT_W'(BLOCK_WORDS);

  ctrl_state_t state, state_nx;

  logic              pending;
  logic              key_loaded;
  logic [KCNT_W-1:0] key_cnt;
  logic [CNT_W-1:0]  in_count;
  logic [CNT_W-1:0]  out_count;
  logic              key_acc;
  logic              s_acc;
  logic              m_acc;
  logic              in_full;
  logic              out_can_load;
  logic              obuf_load;

  assign in_full      = (in_count == BLK_FULL);
  assign m_valid      = (out_count != '0);
  assign m_last       = m_valid && (out_count == CNT_W'(1));
  assign m_acc        = m_valid && m_ready;
  assign out_can_load = (out_count == '0) || ((out_count == CNT_W'(1)) && m_ready);

  // Hold off the start while the last key word is still on its way to the core,
  // and never start and accept a reload word in the same cycle.
  assign core_start   = (state == C_IDLE) && key_loaded && in_full && !pending && !core_valid_word;
  assign key_in_ready = (state == C_KEY) || ((state == C_IDLE) && !core_start);

  // A full buffer already blocks s_ready in the start cycle, keeping plain_text stable.
  assign s_ready = !in_full;
  assign s_acc   = s_valid && s_ready;
  assign key_acc = key_in_valid && key_in_ready;

  always_ff @(posedge clk) begin
    if (reset) state <= C_KEY;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    obuf_load = 1'b0;
    case (state)
      C_KEY: begin
        if (key_acc && (key_cnt == KEY_LAST)) state_nx = C_IDLE;
      end
      C_IDLE: begin
        if (core_start)   state_nx = C_RUN;
        else if (key_acc) state_nx = (key_cnt == KEY_LAST) ? C_IDLE : C_KEY;
      end
      C_RUN: begin
        if (core_done) begin
          if (out_can_load) begin
            obuf_load = 1'b1;
            state_nx  = C_IDLE;
          end else begin
            state_nx  = C_PEND;
          end
        end
      end
      C_PEND: begin
        if (out_can_load) begin
          obuf_load = 1'b1;
          state_nx  = C_IDLE;
        end
      end
      default: state_nx = C_KEY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending         <= 1'b0;
      key_loaded      <= 1'b0;
      key_cnt         <= '0;
      core_key_word   <= '0;
      core_valid_word <= 1'b0;
      blk_count       <= '0;
    end else begin
      pending         <= (state_nx == C_PEND);
      core_valid_word <= key_acc;
      if (key_acc) begin
        core_key_word <= key_in;
        key_cnt       <= (key_cnt == KEY_LAST) ? '0 : key_cnt + 1'b1;
        key_loaded    <= (key_cnt == KEY_LAST);
      end
      if (m_last && m_ready) blk_count <= blk_count + 1'b1;
    end
  end

  aes_word_sipo_piso #(
    .WORD_W    (WORD_W),
    .WORDS     (BLOCK_WORDS),
    .OUT_WORDS (BLOCK_WORDS)
  ) u_in_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (s_acc),
    .push_word (s_data),
    .pop       (1'b0),
    .load      (1'b0),
    .load_data ('0),
    .clear     (core_start),
    .data      (core_plain_text),
    .count     (in_count)
  );

  aes_word_sipo_piso #(
    .WORD_W    (WORD_W),
    .WORDS     (BLOCK_WORDS),
    .OUT_WORDS (1)
  ) u_out_buf (
    .clk       (clk),
    .reset     (reset),
    .push      (1'b0),
    .push_word ('0),
    .pop       (m_acc),
    .load      (obuf_load),
    .load_data (core_cipher_text),
    .clear     (1'b0),
    .data      (m_data),
    .count     (out_count)
  );

endmodule
